// File: rtl/tlul_host_adapter.sv
// TL-UL host adapter: turns a req/gnt/rvalid host port into TL-UL A-channel
// requests, tracks up to MaxReqs outstanding transactions in issue order and
// checks each D-channel response against the expected source and opcode.

package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_host_adapter
  import tlul_pkg::*;
#(
  parameter int MaxReqs = 2,
  localparam int IdxW = (MaxReqs > 1) ? $clog2(MaxReqs) : 1,
  localparam int CntW = $clog2(MaxReqs + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  output logic            gnt_o,
  input  logic            we_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     wdata_i,
  input  logic [3:0]      be_i,
  output logic            rvalid_o,
  output logic [31:0]     rdata_o,
  output logic            err_o,
  output tl_h2d_t         tl_o,
  input  tl_d2h_t         tl_i,
  output logic            dbg_state_o,
  output logic [CntW-1:0] dbg_cnt_o
);

  // Handshake rules (both channels): a transfer happens in a cycle where
  // valid and ready are both high. The A request is held stable while
  // a_valid & ~a_ready. The host holds req_i and its fields until gnt_o.
  // d_ready is tied high, so every d_valid is a completed D transfer.

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e            state_q;
  logic [2:0]        a_opcode_q;
  logic [1:0]        a_size_q;
  logic [7:0]        a_source_q;
  logic [31:0]       a_address_q;
  logic [3:0]        a_mask_q;
  logic [31:0]       a_data_q;

  logic [IdxW-1:0]   iss_idx_q;
  logic [IdxW-1:0]   rsp_idx_q;
  logic [CntW-1:0]   cnt_q;
  logic [MaxReqs-1:0] we_q;

  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              d_fire;
  logic              room;
  logic              rsp_we;
  logic [2:0]        exp_d_op;
  logic              rsp_err;
  logic [7:0]        rsp_src_ext;
  logic [IdxW-1:0]   iss_idx_nxt;
  logic [IdxW-1:0]   rsp_idx_nxt;
  logic [1:0]        unused_addr;

  assign unused_addr = addr_i[1:0];

  // A response retiring in this cycle frees its slot, so a new grant may
  // take it in the same cycle; the counter then stays at MaxReqs.
  assign d_fire = tl_i.d_valid & (cnt_q != '0);
  assign room   = (cnt_q < CntW'(MaxReqs)) | d_fire;
  assign gnt_o  = req_i & room & ((state_q == IDLE) | tl_i.a_ready);

  assign iss_idx_nxt = (iss_idx_q == IdxW'(MaxReqs - 1)) ? '0 : iss_idx_q + 1'b1;
  assign rsp_idx_nxt = (rsp_idx_q == IdxW'(MaxReqs - 1)) ? '0 : rsp_idx_q + 1'b1;

  // Expected response: source is the oldest outstanding index, opcode follows
  // the stored write flag of that slot.
  always_comb begin
    rsp_we      = we_q[rsp_idx_q];
    exp_d_op    = rsp_we ? AccessAck : AccessAckData;
    rsp_src_ext = {{(8 - IdxW){1'b0}}, rsp_idx_q};
    rsp_err     = tl_i.d_error | (tl_i.d_source != rsp_src_ext) |
                  (tl_i.d_opcode != exp_d_op);
  end

  // A-channel FSM with registered request fields and issue-side tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      a_opcode_q  <= 3'h0;
      a_size_q    <= 2'd0;
      a_source_q  <= 8'h00;
      a_address_q <= 32'h0;
      a_mask_q    <= 4'h0;
      a_data_q    <= 32'h0;
      iss_idx_q   <= '0;
      we_q        <= '0;
    end else begin
      if (gnt_o) begin
        state_q     <= SEND;
        a_opcode_q  <= ~we_i ? Get : ((be_i == 4'hF) ? PutFullData : PutPartialData);
        a_size_q    <= 2'd2;
        a_source_q  <= {{(8 - IdxW){1'b0}}, iss_idx_q};
        a_address_q <= {addr_i[31:2], 2'b00};
        a_mask_q    <= we_i ? be_i : 4'hF;
        a_data_q    <= we_i ? wdata_i : 32'h0;
        we_q[iss_idx_q] <= we_i;
        iss_idx_q   <= iss_idx_nxt;
      end else if ((state_q == SEND) && tl_i.a_ready) begin
        state_q <= IDLE;
      end
    end
  end

  // Outstanding counter and response-side index.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      rsp_idx_q <= '0;
    end else begin
      if (gnt_o && !d_fire) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!gnt_o && d_fire) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (d_fire) begin
        rsp_idx_q <= rsp_idx_nxt;
      end
    end
  end

  // Registered host response: one-cycle pulse, data and error zero otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= d_fire;
      rdata_q  <= (d_fire && !rsp_we && !rsp_err) ? tl_i.d_data : 32'h0;
      err_q    <= d_fire & rsp_err;
    end
  end

  // Drive the host-to-device channel from the registered fields.
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = (state_q == SEND);
    tl_o.a_opcode  = a_opcode_q;
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = a_size_q;
    tl_o.a_source  = a_source_q;
    tl_o.a_address = a_address_q;
    tl_o.a_mask    = a_mask_q;
    tl_o.a_data    = a_data_q;
    tl_o.d_ready   = 1'b1;
  end

  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Directed bench for tlul_host_adapter: a table of single transactions with
// hand-computed A fields and responses, plus sequences for the outstanding
// limit, A-channel stall, stray responses and reset mid-transaction.

module tb_tlul_host_adapter;
  import tlul_pkg::*;

  localparam int MaxReqs = 2;
  localparam int CntW = $clog2(MaxReqs + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            req, we, gnt, rvalid, err, dbg_state;
  logic [31:0]     addr, wdata, rdata;
  logic [3:0]      be;
  logic [CntW-1:0] dbg_cnt;
  tl_h2d_t         tl_o;
  tl_d2h_t         tl_i;

  tlul_host_adapter #(.MaxReqs(MaxReqs)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid),
    .rdata_o(rdata), .err_o(err), .tl_o(tl_o), .tl_i(tl_i),
    .dbg_state_o(dbg_state), .dbg_cnt_o(dbg_cnt)
  );

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [2:0]  d_op;
    logic        bad_src;
    logic        d_err;
    logic [31:0] d_data;
    logic [2:0]  exp_op;
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_adata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];
  int   n_vec = 0;
  int   n_err = 0;
  int   iss_n = 0;
  int   rsp_n = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #3;
  endtask

  // Wait (bounded) for gnt_o; leaves time at posedge+4 of the granting cycle.
  task automatic wait_gnt(input string name);
    int k;
    k = 0;
    smp();
    while (!gnt && k < 20) begin
      @(posedge clk);
      #4;
      k++;
    end
    chk(name, gnt, 1'b1);
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [7:0] src,
                         input logic [31:0] data, input logic derr);
    tl_i.d_valid  = 1'b1;
    tl_i.d_opcode = op;
    tl_i.d_source = src;
    tl_i.d_data   = data;
    tl_i.d_error  = derr;
  endtask

  task automatic idle_d();
    tl_i.d_valid  = 1'b0;
    tl_i.d_opcode = 3'h0;
    tl_i.d_source = 8'h00;
    tl_i.d_data   = 32'h0;
    tl_i.d_error  = 1'b0;
  endtask

  task automatic set_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
  endtask

  // Answer the oldest outstanding request and check the host response.
  task automatic respond(input string name, input logic [2:0] op,
                         input logic [31:0] data, input logic [31:0] exp_rdata);
    step();
    drive_d(op, 8'(rsp_n % MaxReqs), data, 1'b0);
    rsp_n++;
    step();
    idle_d();
    smp();
    chk({name, "_rvalid"}, rvalid, 1'b1);
    chk({name, "_rdata"}, rdata, exp_rdata);
    chk({name, "_err"}, err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    tl_h2d_t exp_tl;
    int      grants;
    logic [7:0] src_a, src_b;

    vecs[0] = '{we:1'b0, addr:32'h1000_0007, wdata:32'h0, be:4'h0, d_op:3'h1, bad_src:1'b0,
                d_err:1'b0, d_data:32'hDEAD_BEEF, exp_op:3'h4, exp_addr:32'h1000_0004,
                exp_mask:4'hF, exp_adata:32'h0, exp_rdata:32'hDEAD_BEEF, exp_err:1'b0};
    vecs[1] = '{we:1'b1, addr:32'h2000_0000, wdata:32'h1122_3344, be:4'hF, d_op:3'h0, bad_src:1'b0,
                d_err:1'b0, d_data:32'h55, exp_op:3'h0, exp_addr:32'h2000_0000,
                exp_mask:4'hF, exp_adata:32'h1122_3344, exp_rdata:32'h0, exp_err:1'b0};
    vecs[2] = '{we:1'b1, addr:32'h2000_0006, wdata:32'hAABB_CCDD, be:4'h3, d_op:3'h0, bad_src:1'b0,
                d_err:1'b0, d_data:32'h0, exp_op:3'h1, exp_addr:32'h2000_0004,
                exp_mask:4'h3, exp_adata:32'hAABB_CCDD, exp_rdata:32'h0, exp_err:1'b0};
    vecs[3] = '{we:1'b0, addr:32'h0000_0100, wdata:32'hFFFF_FFFF, be:4'h3, d_op:3'h0, bad_src:1'b0,
                d_err:1'b0, d_data:32'h77, exp_op:3'h4, exp_addr:32'h0000_0100,
                exp_mask:4'hF, exp_adata:32'h0, exp_rdata:32'h0, exp_err:1'b1};
    vecs[4] = '{we:1'b0, addr:32'h0000_0204, wdata:32'h0, be:4'h0, d_op:3'h1, bad_src:1'b1,
                d_err:1'b0, d_data:32'h1234, exp_op:3'h4, exp_addr:32'h0000_0204,
                exp_mask:4'hF, exp_adata:32'h0, exp_rdata:32'h0, exp_err:1'b1};
    vecs[5] = '{we:1'b0, addr:32'h0000_0308, wdata:32'h0, be:4'h0, d_op:3'h1, bad_src:1'b0,
                d_err:1'b1, d_data:32'h5678, exp_op:3'h4, exp_addr:32'h0000_0308,
                exp_mask:4'hF, exp_adata:32'h0, exp_rdata:32'h0, exp_err:1'b1};
    vecs[6] = '{we:1'b1, addr:32'h0000_040C, wdata:32'h0A0B_0C0D, be:4'hC, d_op:3'h1, bad_src:1'b0,
                d_err:1'b0, d_data:32'h99, exp_op:3'h1, exp_addr:32'h0000_040C,
                exp_mask:4'hC, exp_adata:32'h0A0B_0C0D, exp_rdata:32'h0, exp_err:1'b1};
    vecs[7] = '{we:1'b0, addr:32'hFFFF_FFFF, wdata:32'h0, be:4'h0, d_op:3'h1, bad_src:1'b0,
                d_err:1'b0, d_data:32'hCAFE_F00D, exp_op:3'h4, exp_addr:32'hFFFF_FFFC,
                exp_mask:4'hF, exp_adata:32'h0, exp_rdata:32'hCAFE_F00D, exp_err:1'b0};

    req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
    idle_d();
    tl_i.a_ready = 1'b1;

    // ---- reset values ----
    repeat (3) @(posedge clk);
    #3;
    exp_tl = '0;
    exp_tl.d_ready = 1'b1;
    chk("rst_gnt", gnt, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_tl_o", tl_o, exp_tl);
    chk("rst_cnt", dbg_cnt, 0);
    chk("rst_state", dbg_state, 1'b0);
    rst = 1'b0;

    // ---- stray d_valid with nothing outstanding ----
    step();
    drive_d(3'h1, 8'h00, 32'h1111_1111, 1'b0);
    step();
    idle_d();
    smp();
    chk("stray_rvalid", rvalid, 1'b0);
    chk("stray_cnt", dbg_cnt, 0);

    // ---- table of single transactions, zero-wait device ----
    for (int i = 0; i < 8; i++) begin
      logic [7:0] src;
      src = 8'(iss_n % MaxReqs);
      step();
      set_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      wait_gnt($sformatf("v%0d_gnt", i));
      iss_n++;
      step();                                    // N+1: A channel valid
      req = 1'b0;
      smp();
      exp_tl = '0;
      exp_tl.a_valid   = 1'b1;
      exp_tl.a_opcode  = vecs[i].exp_op;
      exp_tl.a_size    = 2'd2;
      exp_tl.a_source  = src;
      exp_tl.a_address = vecs[i].exp_addr;
      exp_tl.a_mask    = vecs[i].exp_mask;
      exp_tl.a_data    = vecs[i].exp_adata;
      exp_tl.d_ready   = 1'b1;
      chk($sformatf("v%0d_a", i), tl_o, exp_tl);
      step();                                    // N+2: D response
      drive_d(vecs[i].d_op, src ^ 8'(vecs[i].bad_src), vecs[i].d_data, vecs[i].d_err);
      rsp_n++;
      smp();
      chk($sformatf("v%0d_a_done", i), tl_o.a_valid, 1'b0);
      step();                                    // N+3: host response
      idle_d();
      smp();
      chk($sformatf("v%0d_rvalid", i), rvalid, 1'b1);
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      step();                                    // N+4: pulse over
      smp();
      chk($sformatf("v%0d_rvalid_off", i),
          {rvalid, err, rdata}, {1'b0, 1'b0, 32'h0});
    end

    // ---- outstanding limit: req held, device withholds D ----
    step();
    set_req(1'b0, 32'h4000_0000, 32'h0, 4'h0);
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      smp();
      if (gnt) grants++;
      step();
    end
    chk("limit_grants", grants, 2);
    chk("limit_cnt", dbg_cnt, 2);
    iss_n += 2;
    drive_d(3'h1, 8'(rsp_n % MaxReqs), 32'h0BAD_CAFE, 1'b0);
    rsp_n++;
    smp();
    chk("limit_gnt_on_rsp", gnt, 1'b1);
    iss_n++;
    step();
    idle_d();
    req = 1'b0;
    smp();
    chk("limit_rvalid", rvalid, 1'b1);
    chk("limit_rdata", rdata, 32'h0BAD_CAFE);
    chk("limit_cnt_held", dbg_cnt, 2);
    respond("drain0", 3'h1, 32'h0000_0D01, 32'h0000_0D01);
    respond("drain1", 3'h1, 32'h0000_0D02, 32'h0000_0D02);
    chk("drain_cnt", dbg_cnt, 0);

    // ---- A-channel stall for 5 cycles ----
    step();
    tl_i.a_ready = 1'b0;
    set_req(1'b1, 32'h3000_0008, 32'h5A5A_0000, 4'h5);
    src_a = 8'(iss_n % MaxReqs);
    wait_gnt("stall_gnt");
    iss_n++;
    exp_tl = '0;
    exp_tl.a_valid   = 1'b1;
    exp_tl.a_opcode  = 3'h1;
    exp_tl.a_size    = 2'd2;
    exp_tl.a_source  = src_a;
    exp_tl.a_address = 32'h3000_0008;
    exp_tl.a_mask    = 4'h5;
    exp_tl.a_data    = 32'h5A5A_0000;
    exp_tl.d_ready   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      smp();
      chk($sformatf("stall%0d_gnt", c), gnt, 1'b0);
      chk($sformatf("stall%0d_a", c), tl_o, exp_tl);
    end
    step();
    tl_i.a_ready = 1'b1;
    smp();
    chk("stall_release_gnt", gnt, 1'b1);
    chk("stall_release_a", tl_o, exp_tl);
    src_b = 8'(iss_n % MaxReqs);
    iss_n++;
    step();
    req = 1'b0;
    smp();
    chk("b2b_a_valid", tl_o.a_valid, 1'b1);
    chk("b2b_a_source", tl_o.a_source, src_b);
    step();
    smp();
    chk("stall_idle_state", dbg_state, 1'b0);
    chk("stall_idle_a_valid", tl_o.a_valid, 1'b0);
    respond("stall_rsp0", 3'h0, 32'h0, 32'h0);
    respond("stall_rsp1", 3'h0, 32'h0, 32'h0);

    // ---- reset while a_valid = 1 and two requests outstanding ----
    step();
    set_req(1'b0, 32'h5000_0000, 32'h0, 4'h0);
    wait_gnt("rst_seq_gnt0");
    step();
    smp();
    chk("rst_seq_gnt1", gnt, 1'b1);
    step();
    tl_i.a_ready = 1'b0;
    req = 1'b0;
    smp();
    chk("rst_seq_pre_a_valid", tl_o.a_valid, 1'b1);
    chk("rst_seq_pre_cnt", dbg_cnt, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_a_valid", tl_o.a_valid, 1'b0);
    chk("rst_async_cnt", dbg_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    iss_n = 0;
    rsp_n = 0;
    tl_i.a_ready = 1'b1;
    step();
    set_req(1'b0, 32'h6000_0010, 32'h0, 4'h0);
    wait_gnt("post_rst_gnt");
    iss_n++;
    step();
    req = 1'b0;
    smp();
    chk("post_rst_source", tl_o.a_source, 8'h00);
    chk("post_rst_addr", tl_o.a_address, 32'h6000_0010);
    respond("post_rst", 3'h1, 32'h0000_600D, 32'h0000_600D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
